// File: rtl/cnt_countdown_pkg.sv
// -----------------------------------------------------------------------------
// cnt_defs -- shared definitions for the countdown timer block.
//   state_e        : FSM state encoding (IDLE/RUN/PAUSE/DONE, 2 bits)
//   BCD_ZERO       : two-digit BCD 00
//   BCD_NINE       : largest legal BCD digit
//   bcd_sanitize() : clamps each digit to 9, then the value to a BCD ceiling
// -----------------------------------------------------------------------------
package cnt_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [7:0] BCD_ZERO = 8'h00;
  localparam logic [3:0] BCD_NINE = 4'd9;

  // Digits are clamped first so the following magnitude compare sees valid
  // BCD, for which a plain binary compare orders values correctly.
  function automatic logic [7:0] bcd_sanitize(input logic [7:0] val,
                                               input logic [7:0] max_val);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = (val[7:4] > BCD_NINE) ? BCD_NINE : val[7:4];
    ones = (val[3:0] > BCD_NINE) ? BCD_NINE : val[3:0];
    return ({tens, ones} > max_val) ? max_val : {tens, ones};
  endfunction

endpackage

// File: rtl/cnt_countdown_bcd2_down.sv
// -----------------------------------------------------------------------------
// bcd2_down -- combinational two-digit BCD decrementer with borrow chain.
//   val[7:0]       : BCD input {tens, ones}
//   bin            : borrow in; when low the value passes through unchanged
//   tens_wrap[3:0] : tens digit to restart at when the tens digit underflows
//   res[7:0]       : BCD result
//   bout           : borrow out, high when the whole pair underflowed
// -----------------------------------------------------------------------------
module bcd2_down
  import cnt_defs::*;
(
  input  logic [7:0] val,
  input  logic       bin,
  input  logic [3:0] tens_wrap,
  output logic [7:0] res,
  output logic       bout
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    res  = val;
    bout = 1'b0;
    if (bin) begin
      if (val[3:0] != 4'd0) begin
        res[3:0] = val[3:0] - 4'd1;
      end else begin
        res[3:0] = BCD_NINE;
        if (val[7:4] != 4'd0) begin
          res[7:4] = val[7:4] - 4'd1;
        end else begin
          res[7:4] = tens_wrap;
          bout     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cnt_countdown.sv
// -----------------------------------------------------------------------------
// cnt_countdown -- loadable MM:SS BCD countdown timer with start/pause control.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   tick       : one-clk 1 Hz enable, decrements one second while running
//   load       : one-clk pulse, copies sanitised set_sec/set_min, goes IDLE
//   start_stop : one-clk pulse, toggles run/pause (and leaves DONE)
//   set_sec    : BCD preset seconds {tens, ones}
//   set_min    : BCD preset minutes {tens, ones}
//   cnt_sec    : BCD current seconds
//   cnt_min    : BCD current minutes
//   running    : high while in RUN
//   done       : high while in DONE
// Event priority within one cycle: load > start_stop > tick.
// -----------------------------------------------------------------------------
module cnt_countdown
  import cnt_defs::*;
#(
  parameter logic [7:0] SEC_MAX = 8'h59,
  parameter logic [7:0] MIN_MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic       start_stop,
  input  logic [7:0] set_sec,
  input  logic [7:0] set_min,
  output logic [7:0] cnt_sec,
  output logic [7:0] cnt_min,
  output logic       running,
  output logic       done
);

  state_e     r_state;
  logic [7:0] r_sec;
  logic [7:0] r_min;

  state_e     w_state_nxt;
  logic [7:0] w_sec_nxt;
  logic [7:0] w_min_nxt;
  logic [7:0] w_sec_dec;
  logic [7:0] w_min_dec;
  logic       w_sec_borrow;
  logic       w_min_borrow;
  logic       w_is_zero;
  logic       w_dec_zero;

  bcd2_down u_sec_dec (
    .val       (r_sec),
    .bin       (1'b1),
    .tens_wrap (SEC_MAX[7:4]),
    .res       (w_sec_dec),
    .bout      (w_sec_borrow)
  );

  bcd2_down u_min_dec (
    .val       (r_min),
    .bin       (w_sec_borrow),
    .tens_wrap (MIN_MAX[7:4]),
    .res       (w_min_dec),
    .bout      (w_min_borrow)
  );

  // A borrow falls out of the minutes stage only when both pairs were 00,
  // so it doubles as the "counter is 00:00" detect.
  assign w_is_zero  = w_min_borrow;
  assign w_dec_zero = (w_sec_dec == BCD_ZERO) && (w_min_dec == BCD_ZERO);

  always_comb begin
    w_state_nxt = r_state;
    w_sec_nxt   = r_sec;
    w_min_nxt   = r_min;
    if (load) begin
      w_sec_nxt   = bcd_sanitize(set_sec, SEC_MAX);
      w_min_nxt   = bcd_sanitize(set_min, MIN_MAX);
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_stop) w_state_nxt = w_is_zero ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (start_stop) begin
            w_state_nxt = ST_PAUSE;
          end else if (tick && !w_is_zero) begin
            w_sec_nxt = w_sec_dec;
            w_min_nxt = w_min_dec;
            if (w_dec_zero) w_state_nxt = ST_DONE;
          end
        end
        ST_PAUSE: begin
          if (start_stop) w_state_nxt = ST_RUN;
        end
        ST_DONE: begin
          w_sec_nxt = BCD_ZERO;
          w_min_nxt = BCD_ZERO;
          if (start_stop) w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_sec   <= BCD_ZERO;
      r_min   <= BCD_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_sec   <= w_sec_nxt;
      r_min   <= w_min_nxt;
    end
  end

  assign cnt_sec = r_sec;
  assign cnt_min = r_min;
  assign running = (r_state == ST_RUN);
  assign done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_cnt_countdown.sv
// -----------------------------------------------------------------------------
// tb_cnt_countdown -- self-checking bench for cnt_countdown.
// Reference model keeps the remaining time as a plain number of seconds and
// the mode as independent flags; BCD is only produced when comparing.
// -----------------------------------------------------------------------------
module tb_cnt_countdown;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       load;
  logic       start_stop;
  logic [7:0] set_sec;
  logic [7:0] set_min;
  logic [7:0] cnt_sec;
  logic [7:0] cnt_min;
  logic       running;
  logic       done;

  cnt_countdown dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .load       (load),
    .start_stop (start_stop),
    .set_sec    (set_sec),
    .set_min    (set_min),
    .cnt_sec    (cnt_sec),
    .cnt_min    (cnt_min),
    .running    (running),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state.
  int m_total = 0;
  bit m_run   = 1'b0;
  bit m_pause = 1'b0;
  bit m_done  = 1'b0;

  function automatic int sanit(input logic [7:0] v);
    int t;
    int o;
    int n;
    t = (int'(v[7:4]) > 9) ? 9 : int'(v[7:4]);
    o = (int'(v[3:0]) > 9) ? 9 : int'(v[3:0]);
    n = t * 10 + o;
    return (n > 59) ? 59 : n;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  task automatic model_reset();
    m_total = 0;
    m_run   = 1'b0;
    m_pause = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic model_step(input bit l, input bit ss, input bit t,
                            input logic [7:0] ps, input logic [7:0] pm);
    if (l) begin
      m_total = sanit(pm) * 60 + sanit(ps);
      m_run   = 1'b0;
      m_pause = 1'b0;
      m_done  = 1'b0;
    end else if (m_done) begin
      if (ss) m_done = 1'b0;
    end else if (m_run) begin
      if (ss) begin
        m_run   = 1'b0;
        m_pause = 1'b1;
      end else if (t && m_total > 0) begin
        m_total = m_total - 1;
        if (m_total == 0) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (m_pause) begin
      if (ss) begin
        m_pause = 1'b0;
        m_run   = 1'b1;
      end
    end else if (ss) begin
      if (m_total == 0) m_done = 1'b1;
      else              m_run  = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sec"}, cnt_sec, to_bcd(m_total % 60));
    check({tag, ".min"}, cnt_min, to_bcd(m_total / 60));
    check({tag, ".running"}, 8'(running), 8'(m_run));
    check({tag, ".done"}, 8'(done), 8'(m_done));
  endtask

  // One clock cycle: drive on the falling edge, let the model follow the
  // rising edge, then drop the one-cycle pulses and let outputs settle.
  task automatic step(input bit l, input bit ss, input bit t,
                      input logic [7:0] ps, input logic [7:0] pm);
    @(negedge clk);
    load       = l;
    start_stop = ss;
    tick       = t;
    set_sec    = ps;
    set_min    = pm;
    @(posedge clk);
    model_step(l, ss, t, ps, pm);
    #1;
    load       = 1'b0;
    start_stop = 1'b0;
    tick       = 1'b0;
  endtask

  initial begin
    bit         l;
    bit         ss;
    bit         t;
    logic [7:0] ps;
    logic [7:0] pm;

    rst        = 1'b0;
    tick       = 1'b0;
    load       = 1'b0;
    start_stop = 1'b0;
    set_sec    = 8'h00;
    set_min    = 8'h00;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset in the middle of a run at 12:34.
    step(1, 0, 0, 8'h34, 8'h12);
    step(0, 1, 0, 8'h00, 8'h00);
    check_all("rst_pre");
    check("rst_pre.running_const", 8'(running), 8'h01);
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    check("rst_async.sec_const", cnt_sec, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 1, 8'h00, 8'h00);
    step(0, 0, 1, 8'h00, 8'h00);
    check_all("rst_idle");

    // Full borrow chain: 10:00 -> 09:59.
    step(1, 0, 0, 8'h00, 8'h10);
    step(0, 1, 0, 8'h00, 8'h00);
    step(0, 0, 1, 8'h00, 8'h00);
    check_all("borrow");
    check("borrow.sec_const", cnt_sec, 8'h59);
    check("borrow.min_const", cnt_min, 8'h09);

    // Expiry at 00:00 on the same edge, then ticks are ignored.
    step(1, 0, 0, 8'h02, 8'h00);
    step(0, 1, 0, 8'h00, 8'h00);
    step(0, 0, 1, 8'h00, 8'h00);
    check_all("expiry1");
    step(0, 0, 1, 8'h00, 8'h00);
    check_all("expiry0");
    check("expiry0.done_const", 8'(done), 8'h01);
    step(0, 0, 1, 8'h00, 8'h00);
    step(0, 0, 1, 8'h00, 8'h00);
    check_all("expiry_hold");

    // Pause ignores ticks.
    step(1, 0, 0, 8'h00, 8'h01);
    step(0, 1, 0, 8'h00, 8'h00);
    step(0, 0, 1, 8'h00, 8'h00);
    check_all("pause_run");
    step(0, 1, 0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00, 8'h00);
    check_all("pause_hold");
    check("pause_hold.sec_const", cnt_sec, 8'h59);
    step(0, 1, 0, 8'h00, 8'h00);
    step(0, 0, 1, 8'h00, 8'h00);
    check_all("pause_resume");
    check("pause_resume.sec_const", cnt_sec, 8'h58);

    // Simultaneous events.
    step(1, 0, 0, 8'h30, 8'h05);
    step(0, 1, 0, 8'h00, 8'h00);
    step(0, 1, 1, 8'h00, 8'h00);
    check_all("ss_tick");
    check("ss_tick.sec_const", cnt_sec, 8'h30);
    step(1, 0, 1, 8'h00, 8'h02);
    check_all("load_tick");
    check("load_tick.min_const", cnt_min, 8'h02);

    // Sanitising and zero start.
    step(1, 0, 0, 8'h7A, 8'h99);
    check_all("sanit");
    check("sanit.sec_const", cnt_sec, 8'h59);
    check("sanit.min_const", cnt_min, 8'h59);
    step(1, 0, 0, 8'h00, 8'h00);
    step(0, 1, 0, 8'h00, 8'h00);
    check_all("zero_start");
    check("zero_start.done_const", 8'(done), 8'h01);
    step(0, 1, 0, 8'h00, 8'h00);
    check_all("done_to_idle");

    // Randomised traffic, biased towards short presets so expiry is frequent.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        @(negedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("rnd_rst");
        @(negedge clk);
        rst = 1'b1;
      end
      l  = ($urandom_range(0, 11) == 0);
      ss = ($urandom_range(0, 6) == 0);
      t  = ($urandom_range(0, 1) == 1);
      ps = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 5));
      pm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step(l, ss, t, ps, pm);
      check_all("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
